axi4_wr_mem_slave: RTL and testbench
====================================

Name: axi4_wr_mem_slave

Overview:
- Synthesizable AXI4 write-channel responder. It models the DDR end of the DMA write path: it accepts AW/W bursts from dma_subsystem's m_axi_* port and commits bytes into an internal word memory.
- It returns a B response per burst and flags protocol violations with SLVERR.
- It replaces the bench-only dummy slave in system integration.
- It exposes a debug read port so benches and the CPU-side checker can inspect the written memory.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; only 32 is supported, so beat size is fixed at 4 bytes.
- MEM_DEPTH, 1024, number of 32-bit words in the backing memory; must be a power of 2.
- BASE_ADDR, 32'h1000_0000, byte address of memory word 0.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  ADDR_WIDTH  burst start byte address.
- s_axi_awlen  in  8  beats minus 1.
- s_axi_awsize  in  3  beat size.
- s_axi_awburst  in  2  burst type.
- s_axi_awvalid  in  1  AW valid.
- s_axi_awready  out  1  AW ready.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8  byte strobes.
- s_axi_wlast  in  1  last beat of burst.
- s_axi_wvalid  in  1  W valid.
- s_axi_wready  out  1  W ready.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  B valid.
- s_axi_bready  in  1  B ready.
- dbg_addr  in  $clog2(MEM_DEPTH)  debug word index.
- dbg_rdata  out  DATA_WIDTH  debug read data; 1-cycle latency.
- err_count  out  16  saturating count of SLVERR responses issued.

Behaviour:
- Reset values: awready=0, wready=0, bvalid=0, bresp=2'b00, err_count=0, state=IDLE. Memory contents are not reset. dbg_rdata is undefined until the first clock after reset.
- FSM states: IDLE -> DATA -> RESP -> IDLE. Only one burst is outstanding at a time.
- IDLE:
  - awready=1, wready=0.
  - On awvalid&&awready, latch addr, len and a bad flag; go to DATA on the next cycle.
  - W beats arriving before the AW handshake are held off because wready=0.
- bad is set if any of the following hold:
  - awburst!=2'b01 (INCR).
  - awsize!=3'b010.
  - awaddr[1:0]!=0.
  - awaddr<BASE_ADDR, or the end address BASE_ADDR+MEM_DEPTH*4 is exceeded by awaddr+(awlen+1)*4; compute this in ADDR_WIDTH+10 bits with no wrap.
  - The burst crosses a 4KB boundary: awaddr[11:0]+(awlen+1)*4 > 4096.
- DATA:
  - awready=0, wready=1.
  - Each W handshake writes the bytes with wstrb=1 into mem[(addr-BASE_ADDR)>>2], but only if bad=0. Then addr+=4 and beat_cnt+=1.
  - The burst ends on the beat where beat_cnt==len, regardless of wlast.
  - wlast=0 on the final beat, or wlast=1 on an earlier beat, sets bad. The write itself still proceeds; the response becomes SLVERR.
  - After the final beat, go to RESP.
- RESP:
  - wready=0, bvalid=1, bresp = bad ? 2'b10 (SLVERR) : 2'b00 (OKAY).
  - bvalid and bresp are held stable until bready. On the bvalid&&bready cycle, go to IDLE; awready=1 in the following cycle.
  - On an SLVERR handshake, err_count+=1, saturating at 16'hFFFF.
- A bad burst writes nothing to memory; all beats are still accepted so the master is never deadlocked.
- Reset asserted mid-burst or mid-response returns to IDLE with outputs at their reset values. Memory writes already committed stay in place.
- Debug port: dbg_rdata <= mem[dbg_addr] every cycle. If the same word is written in that cycle, the old data is returned (read-first).
- bvalid must never assert before the final W beat handshake. The bench checks this.

Decomposition:
- Add to pkg_axi_stream:
  - AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010.
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
  - typedef enum wr_slv_state_t {IDLE, DATA, RESP}.
- One sub-module: sp_bram_be, a single-port write plus independent read port, byte-enable, read-first, 1-cycle read RAM.

Test Plan:
- Aligned INCR write, awaddr=0x1000_0000, awlen=15, size=010, data=i: mem[0..15]=0..15, one bvalid, bresp=00, err_count=0.
- Unaligned awaddr=0x1000_0007, awlen=0: beat accepted, mem unchanged, bresp=10, err_count=1.
- awburst=FIXED(00) or awsize=001: SLVERR, no memory change. Then a following good burst gives OKAY, which shows the FSM recovers.
- Partial strobes wstrb=4'b0101 on mem[4]=0xFFFFFFFF with wdata=0x11223344: mem[4]=0xFF22FF44.
- Protocol abuse: wlast early on beat 2 of awlen=3, then wlast missing on the final beat. Both give bresp=10, and no more than awlen+1 beats are accepted.
- Backpressure: bready held low for 20 cycles. bvalid and bresp stay stable and awready=0 throughout. Reset pulsed during DATA: awready=1 two cycles after reset deasserts and bvalid=0.

Source files
------------

// File: rtl/pkg_axi_stream.sv
// Shared AXI constants and the write-slave state type used by the DDR-side
// write responder.
package pkg_axi_stream;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, DATA, RESP} wr_slv_state_t;

endpackage

// File: rtl/sp_bram_be.sv
// Byte-enable RAM with one write port and an independent read port.
// Reads return the pre-write contents when both ports hit the same word.
module sp_bram_be #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [WIDTH/8-1:0]   be,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [AW-1:0]        raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Non-blocking write and read in the same block gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WIDTH / 8; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_wr_mem_slave.sv
// AXI4 write-channel responder backed by a word memory; one burst in flight,
// malformed bursts are fully accepted but not committed and answered with SLVERR.
module axi4_wr_mem_slave
  import pkg_axi_stream::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [7:0]                   s_axi_awlen,
  input  logic [2:0]                   s_axi_awsize,
  input  logic [1:0]                   s_axi_awburst,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]      s_axi_wstrb,
  input  logic                         s_axi_wlast,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata,
  output logic [15:0]                  err_count
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int EXT_W = ADDR_WIDTH + 10;
  localparam logic [EXT_W-1:0] MEM_LIMIT =
    EXT_W'(BASE_ADDR) + EXT_W'(MEM_DEPTH) * EXT_W'(4);

  wr_slv_state_t         state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            len;
  logic [7:0]            beat_cnt;
  logic                  addr_bad;
  logic                  proto_bad;

  logic                  aw_bad;
  logic [EXT_W-1:0]      aw_start;
  logic [EXT_W-1:0]      aw_end;
  logic [12:0]           page_end;
  logic                  w_hs;
  logic                  last_beat;
  logic                  beat_bad;
  logic                  mem_we;
  logic [IDX_W-1:0]      wr_idx;

  // Range checks are widened so a burst near the top of the address space cannot wrap.
  always_comb begin
    aw_start = EXT_W'(s_axi_awaddr);
    aw_end   = aw_start + EXT_W'({s_axi_awlen, 2'b00}) + EXT_W'(4);
    page_end = {1'b0, s_axi_awaddr[11:0]} + {3'b000, s_axi_awlen, 2'b00} + 13'd4;
    aw_bad   = (s_axi_awburst != AXI_BURST_INCR) ||
               (s_axi_awsize != AXI_SIZE_4B) ||
               (s_axi_awaddr[1:0] != 2'b00) ||
               (aw_start < EXT_W'(BASE_ADDR)) ||
               (aw_end > MEM_LIMIT) ||
               (page_end > 13'd4096);
  end

  assign w_hs      = s_axi_wvalid && s_axi_wready;
  assign last_beat = (beat_cnt == len);
  assign beat_bad  = last_beat ? !s_axi_wlast : s_axi_wlast;

  // wlast misuse only poisons the response; the address check alone gates commits.
  assign mem_we = (state == DATA) && w_hs && !addr_bad;
  assign wr_idx = IDX_W'((addr - BASE_ADDR) >> 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= AXI_RESP_OKAY;
      err_count     <= 16'd0;
      addr          <= '0;
      len           <= 8'd0;
      beat_cnt      <= 8'd0;
      addr_bad      <= 1'b0;
      proto_bad     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            addr          <= s_axi_awaddr;
            len           <= s_axi_awlen;
            beat_cnt      <= 8'd0;
            addr_bad      <= aw_bad;
            proto_bad     <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            state         <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            addr      <= addr + ADDR_WIDTH'(4);
            beat_cnt  <= beat_cnt + 8'd1;
            proto_bad <= proto_bad || beat_bad;
            if (last_beat) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (addr_bad || proto_bad || beat_bad) ?
                              AXI_RESP_SLVERR : AXI_RESP_OKAY;
              state        <= RESP;
            end
          end
        end
        RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            state         <= IDLE;
            if (s_axi_bresp == AXI_RESP_SLVERR && err_count != 16'hFFFF)
              err_count <= err_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sp_bram_be #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH),
    .AW    (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (s_axi_wstrb),
    .waddr (wr_idx),
    .wdata (s_axi_wdata),
    .raddr (dbg_addr),
    .rdata (dbg_rdata)
  );

endmodule

// File: tb/tb_axi4_wr_mem_slave.sv
// Directed bench for axi4_wr_mem_slave: drives bursts, keeps a byte-level memory
// and response model, and compares every meaningful DUT output against it.
module tb_axi4_wr_mem_slave;

  localparam logic [31:0] BASE      = 32'h1000_0000;
  localparam longint      BASE_L    = 64'h1000_0000;
  localparam longint      MEM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_rdata;
  logic [15:0] err_count;

  int          checks = 0;
  int          errors = 0;
  int          model_err = 0;
  logic [31:0] model_mem [1024];
  logic [1:0]  exp_bresp = 2'b00;
  bit          w_done = 1'b0;
  bit          check_en = 1'b0;

  axi4_wr_mem_slave dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awsize  (s_axi_awsize),
    .s_axi_awburst (s_axi_awburst),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .dbg_addr      (dbg_addr),
    .dbg_rdata     (dbg_rdata),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // A burst is bad when it is not a 4-byte INCR burst fully inside the memory window and one 4KB page.
  function automatic bit modelBad(input logic [31:0] a, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
    longint start;
    longint bytes;
    start = longint'({32'b0, a});
    bytes = (longint'({56'b0, len}) + 1) * 4;
    return (burst != 2'b01) || (size != 3'b010) || (a[1:0] != 2'b00) ||
           (start < BASE_L) || (start + bytes > BASE_L + MEM_BYTES) ||
           ((start % 4096) + bytes > 4096);
  endfunction

  task automatic waitSig(input int sel, input string name);
    bit seen;
    seen = 1'b0;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      @(negedge clk);
      case (sel)
        0:       seen = s_axi_awready;
        1:       seen = s_axi_wready;
        default: seen = s_axi_bvalid;
      endcase
    end
    if (!seen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [31:0] d0, input logic [31:0] step,
                               input logic [3:0] strb, input int early_last,
                               input bit drop_last, input int bready_delay);
    bit addr_bad;
    bit seen_b;
    int base_idx;
    logic [31:0] d;
    addr_bad  = modelBad(a, len, size, burst);
    exp_bresp = (addr_bad || drop_last || (early_last >= 0 && early_last < int'(len))) ?
                2'b10 : 2'b00;
    base_idx  = int'((longint'({32'b0, a}) - BASE_L) / 4);
    @(posedge clk); #1;
    w_done        = 1'b0;
    s_axi_awaddr  = a;
    s_axi_awlen   = len;
    s_axi_awsize  = size;
    s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    waitSig(0, "awready");
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      d            = d0 + step * 32'(i);
      s_axi_wdata  = d;
      s_axi_wstrb  = strb;
      s_axi_wlast  = (i == int'(len)) ? !drop_last : (i == early_last);
      s_axi_wvalid = 1'b1;
      waitSig(1, "wready");
      @(posedge clk); #1;
      if (!addr_bad) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model_mem[base_idx + i][8*b +: 8] = d[8*b +: 8];
      end
    end
    w_done = 1'b1;
    // Offer a surplus beat; the slave must not take more than len+1 beats.
    s_axi_wdata = 32'hDEAD_BEEF;
    s_axi_wlast = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("no_extra_beat", 32'(s_axi_wready), 32'd0);
    end
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    seen_b = 1'b0;
    for (int c = 0; c < bready_delay; c++) begin
      @(negedge clk);
      if (seen_b) checkOutput("bvalid_held", 32'(s_axi_bvalid), 32'd1);
      if (s_axi_bvalid) seen_b = 1'b1;
    end
    @(posedge clk); #1;
    s_axi_bready = 1'b1;
    waitSig(2, "bvalid");
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    @(negedge clk);
    checkOutput("bvalid_drop", 32'(s_axi_bvalid), 32'd0);
  endtask

  task automatic checkWord(input int idx, input logic [31:0] lit);
    @(posedge clk); #1;
    dbg_addr = 10'(idx);
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("mem[%0d]", idx), dbg_rdata, model_mem[idx]);
    checkOutput($sformatf("model[%0d]", idx), model_mem[idx], lit);
  endtask

  // Every cycle: response only after the last W beat, matching the model, with AW held off.
  always @(negedge clk) begin
    if (rst) begin
      model_err = 0;
    end else if (check_en) begin
      checkOutput("err_count", 32'(err_count), 32'(model_err));
      if (s_axi_bvalid) begin
        checkOutput("bvalid_after_last_w", 32'(w_done), 32'd1);
        checkOutput("bresp", 32'(s_axi_bresp), 32'(exp_bresp));
        checkOutput("awready_in_resp", 32'(s_axi_awready), 32'd0);
        if (s_axi_bready && exp_bresp == 2'b10 && model_err != 65535) model_err++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_awready", 32'(s_axi_awready), 32'd0);
    checkOutput("rst_wready", 32'(s_axi_wready), 32'd0);
    checkOutput("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    checkOutput("rst_bresp", 32'(s_axi_bresp), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_en = 1'b1;

    $display("[TB] aligned 16-beat INCR burst");
    applyStimulus(BASE, 8'd15, 3'b010, 2'b01, 32'd0, 32'd1, 4'hF, -1, 1'b0, 0);
    for (int i = 0; i < 16; i++) checkWord(i, 32'(i));
    checkOutput("err_after_good", 32'(err_count), 32'd0);

    $display("[TB] unaligned address");
    applyStimulus(BASE + 32'd7, 8'd0, 3'b010, 2'b01, 32'hAAAA_AAAA, 32'd0, 4'hF, -1, 1'b0, 0);
    checkWord(1, 32'd1);
    checkOutput("err_after_unaligned", 32'(err_count), 32'd1);

    $display("[TB] FIXED burst, narrow size, then recovery");
    applyStimulus(BASE + 32'h8, 8'd1, 3'b010, 2'b00, 32'hBBBB_0000, 32'd1, 4'hF, -1, 1'b0, 0);
    applyStimulus(BASE + 32'h8, 8'd1, 3'b001, 2'b01, 32'hCCCC_0000, 32'd1, 4'hF, -1, 1'b0, 0);
    checkWord(2, 32'd2);
    checkWord(3, 32'd3);
    applyStimulus(BASE + 32'h40, 8'd1, 3'b010, 2'b01, 32'hA5A5_0000, 32'd1, 4'hF, -1, 1'b0, 0);
    checkWord(16, 32'hA5A5_0000);
    checkWord(17, 32'hA5A5_0001);
    checkOutput("err_after_fixed_size", 32'(err_count), 32'd3);

    $display("[TB] partial strobes");
    applyStimulus(BASE + 32'h10, 8'd0, 3'b010, 2'b01, 32'hFFFF_FFFF, 32'd0, 4'hF, -1, 1'b0, 0);
    applyStimulus(BASE + 32'h10, 8'd0, 3'b010, 2'b01, 32'h1122_3344, 32'd0, 4'b0101, -1, 1'b0, 0);
    checkWord(4, 32'hFF22_FF44);

    $display("[TB] wlast abuse");
    applyStimulus(BASE + 32'd400, 8'd3, 3'b010, 2'b01, 32'h7000_0000, 32'd1, 4'hF, 1, 1'b0, 0);
    applyStimulus(BASE + 32'd416, 8'd3, 3'b010, 2'b01, 32'h7100_0000, 32'd1, 4'hF, -1, 1'b1, 0);
    checkOutput("err_after_abuse", 32'(err_count), 32'd5);

    $display("[TB] memory window boundaries");
    applyStimulus(BASE + 32'hFF0, 8'd3, 3'b010, 2'b01, 32'hC0DE_0000, 32'd1, 4'hF, -1, 1'b0, 0);
    checkWord(1023, 32'hC0DE_0003);
    applyStimulus(BASE + 32'hFF4, 8'd3, 3'b010, 2'b01, 32'hEEEE_0000, 32'd1, 4'hF, -1, 1'b0, 0);
    checkWord(1021, 32'hC0DE_0001);
    applyStimulus(BASE - 32'd4, 8'd0, 3'b010, 2'b01, 32'hEEEE_EEEE, 32'd0, 4'hF, -1, 1'b0, 0);
    checkWord(0, 32'd0);
    checkOutput("err_after_range", 32'(err_count), 32'd7);

    $display("[TB] B backpressure");
    applyStimulus(BASE + 32'd1200, 8'd1, 3'b010, 2'b01, 32'h3300_0000, 32'd1, 4'hF, -1, 1'b0, 20);
    checkWord(301, 32'h3300_0001);

    $display("[TB] reset during DATA");
    @(posedge clk); #1;
    w_done        = 1'b0;
    s_axi_awaddr  = BASE + 32'd800;
    s_axi_awlen   = 8'd7;
    s_axi_awsize  = 3'b010;
    s_axi_awburst = 2'b01;
    s_axi_awvalid = 1'b1;
    waitSig(0, "awready");
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_axi_wdata  = 32'h5A00_0000 + 32'(i);
      s_axi_wstrb  = 4'hF;
      s_axi_wlast  = 1'b0;
      s_axi_wvalid = 1'b1;
      waitSig(1, "wready");
      @(posedge clk); #1;
      model_mem[200 + i] = 32'h5A00_0000 + 32'(i);
    end
    s_axi_wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_awready", 32'(s_axi_awready), 32'd0);
    checkOutput("midrst_wready", 32'(s_axi_wready), 32'd0);
    checkOutput("midrst_bvalid", 32'(s_axi_bvalid), 32'd0);
    checkOutput("midrst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("postrst_awready", 32'(s_axi_awready), 32'd1);
    checkOutput("postrst_bvalid", 32'(s_axi_bvalid), 32'd0);
    checkWord(200, 32'h5A00_0000);
    checkWord(201, 32'h5A00_0001);

    applyStimulus(BASE + 32'd808, 8'd0, 3'b010, 2'b01, 32'h600D_600D, 32'd0, 4'hF, -1, 1'b0, 0);
    checkWord(202, 32'h600D_600D);
    checkOutput("err_final", 32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
